// File: rtl/pool_pkg.sv
// Shared pooling constants: mode encoding, FSM state encoding, shift clamp helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Window exponents above the supported maximum fall back to the maximum.
  function automatic int unsigned clamp_shift(input int unsigned shift,
                                              input int unsigned shift_max);
    return (shift > shift_max) ? shift_max : shift;
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One channel of the pooling accumulator: load, fold (signed max or sum), finalise.
// Latency: result is combinational and already includes the beat presented this cycle.
// Backpressure: none here; the parent only pulses beat_en on accepted beats.
module pool_lane
  import pool_pkg::*;
#(
  parameter int N         = 16,
  parameter int SHIFT_MAX = 3,
  parameter int SHW       = $clog2(SHIFT_MAX + 1)
) (
  input  logic           clk,
  input  logic           master_rst,
  input  logic           beat_en,
  input  logic           first_beat,
  input  logic           mode,
  input  logic [SHW-1:0] shift,
  input  logic [N-1:0]   in_data,
  output logic [N-1:0]   result
);

  // Headroom of SHIFT_MAX bits lets a full window of sums never overflow.
  localparam int AW = N + SHIFT_MAX;

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] in_ext;
  logic signed [AW-1:0] avg_sh;
  logic                 unused_avg_hi;

  assign in_ext = {{SHIFT_MAX{in_data[N-1]}}, in_data};

  // Next accumulator value: first beat loads, later beats fold by mode.
  always_comb begin
    acc_d = acc_q;
    if (first_beat) begin
      acc_d = in_ext;
    end else if (mode == POOL_AVG) begin
      acc_d = acc_q + in_ext;
    end else if (in_ext > acc_q) begin
      acc_d = in_ext;
    end
  end

  // Arithmetic shift floors toward -inf; the quotient always fits in N bits.
  assign avg_sh        = acc_d >>> shift;
  assign unused_avg_hi = ^avg_sh[AW-1:N];
  assign result        = (mode == POOL_AVG) ? avg_sh[N-1:0] : acc_d[N-1:0];

  // Accumulator register advances only on accepted beats.
  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      acc_q <= '0;
    end else if (beat_en) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pool_accum.sv
// Multi-channel streaming pooling accumulator (max or floor-average over 2^shift beats).
// Latency: last beat accepted -> out_valid one cycle later; sustains one beat per cycle.
// Backpressure: only the final beat of a window stalls, and only while the output register is full and not draining.
module pool_accum
  import pool_pkg::*;
#(
  parameter int N         = 16,
  parameter int CH        = 4,
  parameter int SHIFT_MAX = 3,
  parameter int SHW       = $clog2(SHIFT_MAX + 1)
) (
  input  logic            clk,
  input  logic            master_rst,
  input  logic            clear,
  input  logic            cfg_mode,
  input  logic [SHW-1:0]  cfg_shift,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*N-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*N-1:0] out_data,
  output logic            busy
);

  localparam int CW = SHIFT_MAX + 1;
  localparam int W  = CH * N;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            mode_q;
  logic [SHW-1:0]  shift_q;
  logic            out_valid_q;
  logic [W-1:0]    out_data_q;

  logic [SHW-1:0]  cfg_shift_cl;
  logic            first_beat;
  logic            mode_eff;
  logic [SHW-1:0]  shift_eff;
  logic [CW-1:0]   last_cnt;
  logic            last_beat;
  logic            accept;
  logic            fire_out;
  logic [W-1:0]    lane_result;

  assign cfg_shift_cl = SHW'(clamp_shift(32'(cfg_shift), SHIFT_MAX));

  // In IDLE the live cfg inputs describe the window about to start; mid-window the latched copy rules.
  assign first_beat = (state_q == ST_IDLE);
  assign mode_eff   = first_beat ? cfg_mode : mode_q;
  assign shift_eff  = first_beat ? cfg_shift_cl : shift_q;
  assign last_cnt   = (CW'(1) << shift_eff) - CW'(1);
  assign last_beat  = (cnt_q == last_cnt);

  assign in_ready = !clear && (!last_beat || !out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign fire_out = accept && last_beat;

  // Next state and beat count within the window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !last_beat) begin
          state_d = ST_ACCUM;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          if (last_beat) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; clear abandons any partial window.
  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      state_q <= ST_IDLE;
    end else if (clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Beat counter plus window configuration captured on the first beat.
  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      cnt_q   <= '0;
      mode_q  <= POOL_MAX;
      shift_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept && first_beat) begin
        mode_q  <= cfg_mode;
        shift_q <= cfg_shift_cl;
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    pool_lane #(
      .N         (N),
      .SHIFT_MAX (SHIFT_MAX),
      .SHW       (SHW)
    ) u_lane (
      .clk        (clk),
      .master_rst (master_rst),
      .beat_en    (accept),
      .first_beat (first_beat),
      .mode       (mode_eff),
      .shift      (shift_eff),
      .in_data    (in_data[k*N +: N]),
      .result     (lane_result[k*N +: N])
    );
  end

  // Output register: a new result may overwrite one draining in the same cycle; otherwise hold until taken.
  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (clear) begin
      out_valid_q <= 1'b0;
    end else if (fire_out) begin
      out_valid_q <= 1'b1;
      out_data_q  <= lane_result;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: tb/tb_pool_accum.sv
// Self-checking bench for pool_accum: directed scenarios plus a randomized scoreboard run.
// Latency: outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: out_ready is driven both statically and randomly to exercise final-beat stalls.
module tb_pool_accum;

  localparam int N         = 16;
  localparam int CH        = 4;
  localparam int SHIFT_MAX = 3;
  localparam int SHW       = $clog2(SHIFT_MAX + 1);
  localparam int W         = CH * N;

  typedef logic [W-1:0] vec_t;

  logic           clk = 1'b0;
  logic           master_rst;
  logic           clear;
  logic           cfg_mode;
  logic [SHW-1:0] cfg_shift;
  logic           in_valid;
  logic           in_ready;
  vec_t           in_data;
  logic           out_valid;
  logic           out_ready;
  vec_t           out_data;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  vec_t beat_log[$];
  int   beat_cyc[$];
  vec_t out_log[$];
  int   out_cyc[$];

  pool_accum #(
    .N         (N),
    .CH        (CH),
    .SHIFT_MAX (SHIFT_MAX),
    .SHW       (SHW)
  ) dut (
    .clk        (clk),
    .master_rst (master_rst),
    .clear      (clear),
    .cfg_mode   (cfg_mode),
    .cfg_shift  (cfg_shift),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Record every handshake that will complete on the coming rising edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) begin
      beat_log.push_back(in_data);
      beat_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      out_log.push_back(out_data);
      out_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int lane(input vec_t v, input int k);
    logic [N-1:0] x;
    x = v[k*N +: N];
    return int'($signed(x));
  endfunction

  function automatic vec_t pack4(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0*N +: N] = N'(a);
    v[1*N +: N] = N'(b);
    v[2*N +: N] = N'(c);
    v[3*N +: N] = N'(d);
    return v;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Reference: max = largest signed lane value; avg = mathematical floor of sum / window.
  function automatic vec_t model(input bit mode, input int shift, input vec_t b[$]);
    vec_t r;
    int   s, w, acc, q;
    s = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
    w = 1 << s;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      if (!mode) begin
        acc = lane(b[0], k);
        for (int i = 1; i < w; i++) if (lane(b[i], k) > acc) acc = lane(b[i], k);
        q = acc;
      end else begin
        acc = 0;
        for (int i = 0; i < w; i++) acc += lane(b[i], k);
        q = acc / w;
        if ((acc % w) != 0 && acc < 0) q = q - 1;
      end
      r[k*N +: N] = N'(q);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; optionally randomise out_ready while waiting.
  task automatic drive_beat(input vec_t d, input bit rnd);
    int n;
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (rnd && !ok) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL beat_accept: accepted=%0d after %0d cycles, want 1", ok, n);
    end
  endtask

  task automatic test_reset();
    master_rst = 1'b1;
    clear      = 1'b0;
    cfg_mode   = 1'b0;
    cfg_shift  = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid: got %b want 0", out_valid); end
    @(posedge clk);
    #1 master_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    clear = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_blocks_ready: got %b want 0", in_ready); end
    clear = 1'b0;
    tick();
  endtask

  task automatic test_max();
    vec_t b[$];
    vec_t exp, got;
    int   nb, lastc, gotc;
    cfg_mode  = 1'b0;
    cfg_shift = SHW'(2);
    out_ready = 1'b1;
    b.push_back(pack4(3, -1, rnd16(), rnd16()));
    b.push_back(pack4(-7, -2, rnd16(), rnd16()));
    b.push_back(pack4(12, -3, rnd16(), rnd16()));
    b.push_back(pack4(5, -4, rnd16(), rnd16()));
    exp = model(1'b0, 2, b);
    nb  = out_log.size();
    foreach (b[i]) drive_beat(b[i], 1'b0);
    lastc = beat_cyc[beat_cyc.size()-1];
    repeat (3) tick();
    got  = (out_log.size() > nb) ? out_log[nb] : 'x;
    gotc = (out_cyc.size() > nb) ? out_cyc[nb] : -1;
    checks++;
    if (out_log.size() !== nb + 1) begin errors++; $display("FAIL max_count: got %0d want %0d", out_log.size() - nb, 1); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL max_result: got %h want %h", got, exp); end
    checks++;
    if (lane(got, 0) !== 12) begin errors++; $display("FAIL max_lane0: got %0d want 12", lane(got, 0)); end
    checks++;
    if (lane(got, 1) !== -1) begin errors++; $display("FAIL max_lane1: got %0d want -1", lane(got, 1)); end
    checks++;
    if (gotc !== lastc + 1) begin errors++; $display("FAIL max_latency: got cycle %0d want %0d", gotc, lastc + 1); end
  endtask

  task automatic test_avg();
    vec_t b[$];
    vec_t exp, got;
    int   nb;
    cfg_mode  = 1'b1;
    cfg_shift = SHW'(3);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) b.push_back(pack4(i + 1, -3, (i == 0) ? -1 : 0, rnd16()));
    exp = model(1'b1, 3, b);
    nb  = out_log.size();
    foreach (b[i]) drive_beat(b[i], 1'b0);
    repeat (3) tick();
    got = (out_log.size() > nb) ? out_log[nb] : 'x;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL avg_result: got %h want %h", got, exp); end
    checks++;
    if (lane(got, 0) !== 4) begin errors++; $display("FAIL avg_lane0: got %0d want 4", lane(got, 0)); end
    checks++;
    if (lane(got, 1) !== -3) begin errors++; $display("FAIL avg_lane1: got %0d want -3", lane(got, 1)); end
    checks++;
    if (lane(got, 2) !== -1) begin errors++; $display("FAIL avg_lane2_floor: got %0d want -1", lane(got, 2)); end
  endtask

  task automatic test_backpressure();
    vec_t a[$];
    vec_t b[$];
    vec_t exp_a, exp_b, got;
    int   nb, nbeat;
    cfg_mode  = 1'b0;
    cfg_shift = SHW'(2);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) a.push_back(pack4(rnd16(), rnd16(), rnd16(), rnd16()));
    for (int i = 0; i < 4; i++) b.push_back(pack4(rnd16(), rnd16(), rnd16(), rnd16()));
    exp_a = model(1'b0, 2, a);
    exp_b = model(1'b0, 2, b);
    nb    = out_log.size();
    nbeat = beat_log.size();
    foreach (a[i]) drive_beat(a[i], 1'b0);
    for (int i = 0; i < 3; i++) drive_beat(b[i], 1'b0);
    in_valid = 1'b1;
    in_data  = b[3];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b want 0", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_a) begin
        errors++;
        $display("FAIL bp_hold: got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, exp_a);
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_b) begin
      errors++;
      $display("FAIL bp_next_result: got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, exp_b);
    end
    repeat (3) tick();
    checks++;
    if (out_log.size() !== nb + 2) begin errors++; $display("FAIL bp_out_count: got %0d want 2", out_log.size() - nb); end
    got = (out_log.size() > nb) ? out_log[nb] : 'x;
    checks++;
    if (got !== exp_a) begin errors++; $display("FAIL bp_first_out: got %h want %h", got, exp_a); end
    checks++;
    if (beat_log.size() !== nbeat + 8) begin errors++; $display("FAIL bp_beat_count: got %0d want 8", beat_log.size() - nbeat); end
  endtask

  task automatic test_shift0();
    vec_t b[$];
    vec_t got;
    int   nb, nbb, gc, bc;
    cfg_mode  = 1'b0;
    cfg_shift = '0;
    out_ready = 1'b1;
    b.push_back(pack4('h0011, 'h0011, 'h0011, 'h0011));
    b.push_back(pack4('h8000, 'h8000, 'h8000, 'h8000));
    b.push_back(pack4('h7FFF, 'h7FFF, 'h7FFF, 'h7FFF));
    nb  = out_log.size();
    nbb = beat_log.size();
    foreach (b[i]) drive_beat(b[i], 1'b0);
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      got = (out_log.size() > nb + i) ? out_log[nb+i] : 'x;
      gc  = (out_cyc.size() > nb + i) ? out_cyc[nb+i] : -1;
      bc  = (beat_cyc.size() > nbb + i) ? beat_cyc[nbb+i] : -100;
      checks++;
      if (got !== b[i]) begin errors++; $display("FAIL w1_data[%0d]: got %h want %h", i, got, b[i]); end
      checks++;
      if (gc !== bc + 1) begin errors++; $display("FAIL w1_latency[%0d]: got cycle %0d want %0d", i, gc, bc + 1); end
      checks++;
      if (bc !== beat_cyc[nbb] + i) begin errors++; $display("FAIL w1_throughput[%0d]: got cycle %0d want %0d", i, bc, beat_cyc[nbb] + i); end
    end
  endtask

  task automatic test_clear();
    vec_t b[$];
    vec_t got;
    int   nb;
    cfg_mode  = 1'b1;
    cfg_shift = SHW'(2);
    out_ready = 1'b1;
    nb = out_log.size();
    drive_beat(pack4(rnd16(), rnd16(), rnd16(), rnd16()), 1'b0);
    drive_beat(pack4(rnd16(), rnd16(), rnd16(), rnd16()), 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy_before: got %b want 1", busy); end
    tick();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = pack4(rnd16(), rnd16(), rnd16(), rnd16());
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready: got %b want 0", in_ready); end
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy_after: got %b want 0", busy); end
    tick();
    for (int i = 0; i < 4; i++) b.push_back(pack4(9, 9, 9, 9));
    foreach (b[i]) drive_beat(b[i], 1'b0);
    repeat (3) tick();
    got = (out_log.size() > nb) ? out_log[nb] : 'x;
    checks++;
    if (out_log.size() !== nb + 1) begin errors++; $display("FAIL clear_out_count: got %0d want 1", out_log.size() - nb); end
    checks++;
    if (got !== pack4(9, 9, 9, 9)) begin errors++; $display("FAIL clear_result: got %h want %h", got, pack4(9, 9, 9, 9)); end
  endtask

  task automatic test_rst_mid();
    vec_t b[$];
    vec_t exp, got;
    int   nb;
    cfg_mode  = 1'b0;
    cfg_shift = SHW'(2);
    out_ready = 1'b1;
    nb = out_log.size();
    drive_beat(pack4(rnd16(), rnd16(), rnd16(), rnd16()), 1'b0);
    drive_beat(pack4(rnd16(), rnd16(), rnd16(), rnd16()), 1'b0);
    master_rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    @(negedge clk);
    tick();
    master_rst = 1'b0;
    out_ready  = 1'b0;
    for (int i = 0; i < 4; i++) drive_beat(pack4(rnd16(), rnd16(), rnd16(), rnd16()), 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
    tick();
    master_rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL rst_async_data: got %h want 0", out_data); end
    @(negedge clk);
    tick();
    master_rst = 1'b0;
    out_ready  = 1'b1;
    checks++;
    if (out_log.size() !== nb) begin errors++; $display("FAIL rst_no_output: got %0d want 0", out_log.size() - nb); end
    for (int i = 0; i < 4; i++) b.push_back(pack4(rnd16(), rnd16(), rnd16(), rnd16()));
    exp = model(1'b1, 2, b);
    cfg_mode  = 1'b1;
    cfg_shift = SHW'(2);
    drive_beat(b[0], 1'b0);
    cfg_mode  = 1'b0;
    cfg_shift = SHW'(3);
    for (int i = 1; i < 4; i++) drive_beat(b[i], 1'b0);
    repeat (3) tick();
    got = (out_log.size() > nb) ? out_log[nb] : 'x;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL rst_recover_result: got %h want %h", got, exp); end
  endtask

  task automatic test_random();
    vec_t exp_q[$];
    vec_t b[$];
    vec_t got;
    int   nb, s, gap;
    bit   m;
    nb = out_log.size();
    for (int w = 0; w < 30; w++) begin
      m = 1'($urandom_range(0, 1));
      s = int'($urandom_range(0, SHIFT_MAX));
      b = {};
      for (int i = 0; i < (1 << s); i++) b.push_back(pack4(rnd16(), rnd16(), rnd16(), rnd16()));
      exp_q.push_back(model(m, s, b));
      cfg_mode  = m;
      cfg_shift = SHW'(s);
      for (int i = 0; i < b.size(); i++) begin
        gap = int'($urandom_range(0, 2));
        repeat (gap) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        drive_beat(b[i], 1'b1);
        if (i == 0) begin
          cfg_mode  = 1'($urandom_range(0, 1));
          cfg_shift = SHW'($urandom_range(0, SHIFT_MAX));
        end
      end
    end
    out_ready = 1'b1;
    repeat (5) tick();
    checks++;
    if (out_log.size() !== nb + exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d want %0d", out_log.size() - nb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (out_log.size() > nb + i) ? out_log[nb+i] : 'x;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL rand_result[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_avg();
    test_backpressure();
    test_shift0();
    test_clear();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_accum.md
Name: pool_accum

Overview:
- Multi-channel streaming pooling accumulator; parametrised successor to the single-lane max register.
- Folds a window of 2^cfg_shift input beats per channel into one result, using either signed max or floor average.
- Sits between the conv/activation stage and the line buffer of the next layer.
- Valid/ready on both sides; one-entry output register; sustains 1 beat/cycle.

Parameters:
- N, 16, lane data width (signed two's complement)
- CH, 4, number of parallel channels/lanes
- SHIFT_MAX, 3, max log2 window length (window up to 8 beats)
- SHW, $clog2(SHIFT_MAX+1), width of cfg_shift

Ports:
- clk  input  1  clock, all logic rising-edge
- master_rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous flush of partial window and output register
- cfg_mode  input  1  0 = max pooling, 1 = average pooling
- cfg_shift  input  SHW  window = 2^cfg_shift beats; values > SHIFT_MAX are clamped to SHIFT_MAX
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_data  input  CH*N  lane k at bits [k*N +: N]
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts when out_valid && out_ready
- out_data  output  CH*N  pooled result, same lane packing
- busy  output  1  high while a window is partially accumulated or out_valid is high

Behaviour:
- Reset: master_rst high asynchronously clears the state to IDLE, cnt, accumulators, out_valid and out_data to 0. in_ready reads 1 after release (unless clear is high); busy reads 0.
- State machine:
  - IDLE (cnt==0), ACCUM (0<cnt<window).
  - First accepted beat in IDLE latches cfg_mode/cfg_shift into mode_q/shift_q and loads the accumulators with the beat.
  - IDLE->ACCUM on that beat when window>1.
  - ACCUM->IDLE on the last beat.
  - cfg inputs are ignored mid-window.
- Window of 1 (cfg_shift=0): each beat goes straight to the output register; result equals in_data.
- Max mode: acc_k <= (in_k > acc_k, signed) ? in_k : acc_k.
- Avg mode:
  - acc_k is N+SHIFT_MAX bits, sign-extended sum.
  - Result = acc_k >>> shift_q (arithmetic, floor toward -inf), truncated to N bits; no overflow is possible.
- Completion: on the accepted last beat, the final value is computed combinationally, including that beat, and registered into out_data. out_valid rises the next cycle. Latency is last beat accepted -> out_valid = 1 cycle.
- in_ready = !clear && (cnt != window-1 || !out_valid || out_ready).
  - Non-final beats are always accepted.
  - The final beat waits only if the output register is occupied and not draining.
- Simultaneous output handshake and final-beat accept: out_data is replaced by the new result and out_valid stays 1 (back-to-back windows with no bubble).
- out_valid && !out_ready: out_data and out_valid are held stable (AXI-style; no change until the handshake).
- clear:
  - Synchronous and highest priority after master_rst.
  - Forces IDLE, cnt=0, out_valid=0 next cycle.
  - in_ready is low during clear, so no beat is lost silently.
  - out_data is not required to be zeroed.
- Reset mid-window: the partial window is discarded; no output is produced.
- cnt width is SHIFT_MAX+1 bits (covers 2^SHIFT_MAX - 1). Wrap is impossible because cnt returns to 0 on the last beat.

Decomposition:
- pool_pkg:
  - Constants POOL_MAX=1'b0, POOL_AVG=1'b1.
  - State encoding ST_IDLE/ST_ACCUM.
  - Function clamp_shift.
- Sub-module pool_lane:
  - One channel's accumulator: load/accumulate/finalise for both modes.
  - Instantiated CH times via generate.
  - The top keeps the FSM, counter, handshake and output register.

Test Plan:
- Max, cfg_shift=2, CH=4: beats lane0 = 3, -7, 12, 5; lane1 = -1, -2, -3, -4 -> out lane0 = 12, lane1 = -1, out_valid one cycle after the 4th accept.
- Avg, cfg_shift=3: lane0 = 1..8 -> sum 36 -> out 4; lane1 = eight beats of -3 -> -24>>>3 = -3; lane2 = -1,0,0,0,0,0,0,0 -> -1 (floor).
- Back-pressure: out_ready=0 with a result held and the next window's first 3 beats streamed:
  - in_ready stays 1 through beat 3 and drops at beat 4.
  - Raise out_ready: first result drains, the 4th beat is accepted in the same cycle, and the next result appears the cycle after.
  - No beat is lost or duplicated.
- cfg_shift=0: continuous in_valid with out_ready=1 and values 0x0011, 0x8000, 0x7FFF -> identical values out, 1-cycle latency, 100% throughput.
- clear asserted after 2 of 4 beats, then a fresh window of 9,9,9,9 (avg) -> single output 9; no result from the aborted window.
- master_rst pulsed mid-window and while out_valid=1 -> out_valid=0 and out_data=0 immediately (asynchronous). The next window after release produces the correct result; changing cfg_mode mid-window has no effect.
